// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and types for the stack CPU stages.
// Decode, the stack and writeback all size their stack interfaces from here.
package cpu_pipe_pkg;

  // Width of one stack entry
  localparam int DATA_W   = 35;
  // Width of the per-instruction pop count
  localparam int POP_W    = 11;
  // Largest number of result words one instruction may push
  localparam int MAX_PUSH = 4;
  // Width of the per-instruction push count
  localparam int CNT_W    = 3;
  // Width needed to select one of the MAX_PUSH result words
  localparam int WB_IDX_W = $clog2(MAX_PUSH);

  // Writeback sequencing state
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  // Limit a requested push count to what the write port can serialise
  function automatic logic [CNT_W-1:0] clamp_push(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(MAX_PUSH);
    if (cnt > lim) begin
      return lim;
    end else begin
      return cnt;
    end
  endfunction

  // True when a requested push count exceeds the architectural limit
  function automatic logic push_overflow(input logic [CNT_W-1:0] cnt);
    return (cnt > CNT_W'(MAX_PUSH));
  endfunction

endpackage

// File: rtl/cpu_writeback.sv
// Stage-5 writeback: retires one stage-4 instruction per handshake, applying
// its pops and serialising up to MAX_PUSH result words onto the single-entry
// stack write port. Multi-word instructions hold stage 4 while they drain.
module cpu_writeback
  import cpu_pipe_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_4a,
  input  logic                       kill_4a,
  input  logic [POP_W-1:0]           st__to_pop_4a,
  input  logic [CNT_W-1:0]           c__to_push_4a,
  input  logic [MAX_PUSH*DATA_W-1:0] wb__data_4a,
  output logic                       stall_4a,
  output logic                       st__push_5a,
  output logic [POP_W-1:0]           st__to_pop_5a,
  output logic [DATA_W-1:0]          st__to_push_5a,
  output logic                       wb__busy_5a,
  output logic                       wb__err_5a
);

  wb_state_t           r_state;
  logic [CNT_W-1:0]    r_rem;      // words still to be emitted from the buffer
  logic [CNT_W-1:0]    r_idx;      // buffer slot emitted next
  logic [DATA_W-1:0]   r_words [1:MAX_PUSH-1];
  logic                r_push;
  logic [POP_W-1:0]    r_pop;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;

  logic                w_accept;
  logic                w_ovf;
  logic [CNT_W-1:0]    w_n;
  logic [DATA_W-1:0]   w_word0;
  logic [DATA_W-1:0]   w_drain_word;

  // Decode the handshake and the clamped push count of the offered instruction
  always_comb begin
    w_accept = 1'b0;
    w_ovf    = 1'b0;
    w_n      = '0;
    w_word0  = wb__data_4a[DATA_W-1:0];
    if ((r_state == IDLE) && valid_4a && !kill_4a) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    w_ovf = push_overflow(c__to_push_4a);
    w_n   = clamp_push(c__to_push_4a);
  end

  // Select the buffered word that the next drain cycle emits
  always_comb begin
    w_drain_word = '0;
    if (r_rem != {CNT_W{1'b0}}) begin
      w_drain_word = r_words[r_idx[WB_IDX_W-1:0]];
    end else begin
      w_drain_word = '0;
    end
  end

  // Writeback FSM: accepts in IDLE, emits buffered words one per cycle in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_push  <= 1'b0;
      r_pop   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      for (int i = 1; i < MAX_PUSH; i++) begin
        r_words[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pop <= st__to_pop_4a;
            if (w_ovf) begin
              r_err <= 1'b1;
            end
            if (w_n != {CNT_W{1'b0}}) begin
              r_push <= 1'b1;
              r_data <= w_word0;
            end else begin
              r_push <= 1'b0;
              r_data <= '0;
            end
            if (w_n >= CNT_W'(2)) begin
              // Word 0 goes out now; words 1..n-1 wait in the buffer.
              for (int i = 1; i < MAX_PUSH; i++) begin
                r_words[i] <= wb__data_4a[i*DATA_W +: DATA_W];
              end
              r_rem   <= w_n - CNT_W'(1);
              r_idx   <= CNT_W'(1);
              r_state <= DRAIN;
            end else begin
              r_rem   <= '0;
              r_idx   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_push <= 1'b0;
            r_pop  <= '0;
            r_data <= '0;
          end
        end
        DRAIN: begin
          // Pops were applied with word 0, so drain cycles never pop.
          r_pop <= '0;
          if (r_rem != {CNT_W{1'b0}}) begin
            r_push <= 1'b1;
            r_data <= w_drain_word;
            r_idx  <= r_idx + CNT_W'(1);
            r_rem  <= r_rem - CNT_W'(1);
          end else begin
            // Last word is already on the port: leave one bubble and reopen.
            r_push  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rem   <= '0;
          r_idx   <= '0;
          r_push  <= 1'b0;
          r_pop   <= '0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign stall_4a       = (r_state == DRAIN);
  assign wb__busy_5a    = (r_state == DRAIN);
  assign st__push_5a    = r_push;
  assign st__to_pop_5a  = r_pop;
  assign st__to_push_5a = r_data;
  assign wb__err_5a     = r_err;

endmodule
